// File: rtl/fp16_pkg.sv
// Shared fp16 definitions: field widths, bias, special encodings and the divider FSM state type.
package fp16_pkg;

   localparam int unsigned EXP_W  = 5;
   localparam int unsigned FRAC_W = 10;
   localparam int unsigned BIAS   = 15;

   // Mantissa with hidden bit, and quotient/remainder width (one guard bit above the mantissa)
   localparam int unsigned MANT_W = FRAC_W + 1;
   localparam int unsigned QUOT_W = MANT_W + 1;

   localparam logic [15:0] FP16_QNAN = 16'h7E00;
   localparam logic [14:0] FP16_INF  = 15'h7C00;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      NORM
   } state_t;

endpackage

// File: rtl/fp16_divider_if.sv
// Operand/result bundle of the fp16 divider with start/done handshake.
interface fp16_divider_if;
   import fp16_pkg::*;

   logic        start;
   logic [15:0] flp_a;
   logic [15:0] flp_b;
   logic [15:0] quot;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic        overflow;
   logic        underflow;
   logic        invalid;

   modport master (
      output start, flp_a, flp_b,
      input  quot, busy, done, div_by_zero, overflow, underflow, invalid
   );

   modport slave (
      input  start, flp_a, flp_b,
      output quot, busy, done, div_by_zero, overflow, underflow, invalid
   );

endinterface

// File: rtl/fp16_mant_div.sv
// Restoring mantissa divider: one quotient bit per step, 12 steps per division.
import fp16_pkg::*;

module fp16_mant_div (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [MANT_W-1:0] ma,
   input  logic [MANT_W-1:0] mb,
   output logic [QUOT_W-1:0] q,
   output logic              last
);

   logic [QUOT_W-1:0] r;
   logic [MANT_W-1:0] mb_r;
   logic [3:0]        cnt;
   logic              ge;
   logic [QUOT_W-1:0] diff;

   // Trial subtraction for the current step; last flags the final quotient bit
   always_comb begin
      ge   = (r >= {1'b0, mb_r});
      diff = ge ? (r - {1'b0, mb_r}) : r;
      last = (cnt == 4'(QUOT_W - 1));
   end

   // Remainder, quotient shift register and step counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r    <= '0;
         q    <= '0;
         mb_r <= '0;
         cnt  <= '0;
      end else if (load) begin
         r    <= {1'b0, ma};
         q    <= '0;
         mb_r <= mb;
         cnt  <= '0;
      end else if (step) begin
         // diff < mb here, so its top bit is always zero and the shift loses nothing
         r   <= diff << 1;
         q   <= {q[QUOT_W-2:0], ge};
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/fp16_divider.sv
// Sequential fp16 divider: classification, exponent path, FSM and result registers.
import fp16_pkg::*;

module fp16_divider (
   input  logic          clk,
   input  logic          rst,
   fp16_divider_if.slave bus
);

   state_t state, state_nx;
   logic   accept, load, step;

   logic [EXP_W-1:0]  exp_a, exp_b;
   logic              sign_in;
   logic              a_zero, b_zero, any_nan, special;
   logic signed [6:0] e_calc;

   logic              sign_r;
   logic signed [6:0] e_r;
   logic signed [6:0] e_fin;
   logic [FRAC_W-1:0] frac_fin;

   logic [QUOT_W-1:0] q;
   logic              last;

   assign exp_a   = bus.flp_a[14:10];
   assign exp_b   = bus.flp_b[14:10];
   assign sign_in = bus.flp_a[15] ^ bus.flp_b[15];
   assign a_zero  = (exp_a == '0);
   assign b_zero  = (exp_b == '0);
   assign any_nan = (exp_a == '1) || (exp_b == '1);
   assign special = any_nan || a_zero || b_zero;
   assign e_calc  = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + $signed(7'(BIAS));

   assign bus.busy = (state != IDLE);

   fp16_mant_div u_mant_div (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .ma   ({1'b1, bus.flp_a[9:0]}),
      .mb   ({1'b1, bus.flp_b[9:0]}),
      .q    (q),
      .last (last)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state and divider control
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      load     = 1'b0;
      step     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (!special) begin
                  load     = 1'b1;
                  state_nx = DIV;
               end
            end
         end
         DIV: begin
            step = 1'b1;
            if (last) state_nx = NORM;
         end
         NORM:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Normalise the finished quotient: a leading zero costs one exponent step
   always_comb begin
      e_fin    = q[QUOT_W-1] ? e_r : (e_r - 7'sd1);
      frac_fin = q[QUOT_W-1] ? q[FRAC_W:1] : q[FRAC_W-1:0];
   end

   // Result, flag and done registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.quot        <= '0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.overflow    <= 1'b0;
         bus.underflow   <= 1'b0;
         bus.invalid     <= 1'b0;
         sign_r          <= 1'b0;
         e_r             <= '0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
            bus.invalid     <= 1'b0;
            if (any_nan || (a_zero && b_zero)) begin
               bus.quot    <= FP16_QNAN;
               bus.invalid <= 1'b1;
               bus.done    <= 1'b1;
            end else if (b_zero) begin
               bus.quot        <= {sign_in, FP16_INF};
               bus.div_by_zero <= 1'b1;
               bus.done        <= 1'b1;
            end else if (a_zero) begin
               bus.quot <= {sign_in, 15'b0};
               bus.done <= 1'b1;
            end else begin
               sign_r <= sign_in;
               e_r    <= e_calc;
            end
         end
         if (state == NORM) begin
            bus.done <= 1'b1;
            if (e_fin >= 7'sd31) begin
               bus.quot     <= {sign_r, FP16_INF};
               bus.overflow <= 1'b1;
            end else if (e_fin <= 7'sd0) begin
               bus.quot      <= {sign_r, 15'b0};
               bus.underflow <= 1'b1;
            end else begin
               bus.quot <= {sign_r, e_fin[EXP_W-1:0], frac_fin};
            end
         end
      end
   end

endmodule

// File: tb/tb_fp16_divider.sv
// Directed self-checking bench for fp16_divider.
module tb_fp16_divider;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   fp16_divider_if bus ();

   fp16_divider dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one operation and wait (bounded) for done; flags = {div_by_zero, overflow, underflow, invalid}
   task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] q, output logic [3:0] flags,
                          output int lat, output int busy_cnt, output bit got);
      @(negedge clk);
      bus.start = 1'b1;
      bus.flp_a = a;
      bus.flp_b = b;
      @(negedge clk);
      bus.start = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      got      = 1'b0;
      q        = '0;
      flags    = '0;
      while (lat <= 40) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            got   = 1'b1;
            q     = bus.quot;
            flags = {bus.div_by_zero, bus.overflow, bus.underflow, bus.invalid};
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (bus.quot !== 16'h0000) begin
         bad++; $display("FAIL reset_quot got=%h exp=0000", bus.quot);
      end
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
         bad++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy, bus.done});
      end
      total++;
      if ({bus.div_by_zero, bus.overflow, bus.underflow, bus.invalid} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags got=%b exp=0000",
                         {bus.div_by_zero, bus.overflow, bus.underflow, bus.invalid});
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [15:0] q; logic [3:0] f; int lat, bc; bit got;
      run_div(16'h4600, 16'h4000, q, f, lat, bc, got);
      total++;
      if (!got) begin bad++; $display("FAIL basic_timeout got=none exp=done"); end
      total++;
      if (q !== 16'h4200) begin bad++; $display("FAIL basic_quot got=%h exp=4200", q); end
      total++;
      if (f !== 4'b0000) begin bad++; $display("FAIL basic_flags got=%b exp=0000", f); end
      total++;
      if (lat !== 14) begin bad++; $display("FAIL basic_latency got=%0d exp=14", lat); end
      total++;
      if (bc !== 13) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=13", bc); end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", bus.done); end
   endtask

   task automatic test_normalise;
      logic [15:0] q; logic [3:0] f; int lat, bc; bit got;
      run_div(16'h3C00, 16'h4200, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h3555 || f !== 4'b0000 || lat !== 14) begin
         bad++; $display("FAIL third got=%h/%b/%0d exp=3555/0000/14", q, f, lat);
      end
      run_div(16'hC800, 16'h3800, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'hCC00 || f !== 4'b0000) begin
         bad++; $display("FAIL neg_eight_half got=%h/%b exp=cc00/0000", q, f);
      end
   endtask

   task automatic test_special;
      logic [15:0] q; logic [3:0] f; int lat, bc; bit got;
      run_div(16'h4500, 16'h0000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h7C00 || f !== 4'b1000 || lat !== 1) begin
         bad++; $display("FAIL div_zero got=%h/%b/%0d exp=7c00/1000/1", q, f, lat);
      end
      run_div(16'h0000, 16'h0000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h7E00 || f !== 4'b0001 || lat !== 1) begin
         bad++; $display("FAIL zero_zero got=%h/%b/%0d exp=7e00/0001/1", q, f, lat);
      end
      run_div(16'h8000, 16'h4000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h8000 || f !== 4'b0000 || lat !== 1) begin
         bad++; $display("FAIL neg_zero got=%h/%b/%0d exp=8000/0000/1", q, f, lat);
      end
      run_div(16'hFC00, 16'h0000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h7E00 || f !== 4'b0001) begin
         bad++; $display("FAIL inf_over_zero got=%h/%b exp=7e00/0001", q, f);
      end
      run_div(16'hC200, 16'h0000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'hFC00 || f !== 4'b1000) begin
         bad++; $display("FAIL neg_div_zero got=%h/%b exp=fc00/1000", q, f);
      end
   endtask

   task automatic test_range;
      logic [15:0] q; logic [3:0] f; int lat, bc; bit got;
      run_div(16'h7BFF, 16'h1400, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h7C00 || f !== 4'b0100 || lat !== 14) begin
         bad++; $display("FAIL overflow got=%h/%b/%0d exp=7c00/0100/14", q, f, lat);
      end
      run_div(16'h0400, 16'h7800, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h0000 || f !== 4'b0010 || lat !== 14) begin
         bad++; $display("FAIL underflow got=%h/%b/%0d exp=0000/0010/14", q, f, lat);
      end
   endtask

   task automatic test_ignored_start;
      int lat; bit got;
      @(negedge clk);
      bus.start = 1'b1; bus.flp_a = 16'h4600; bus.flp_b = 16'h4000;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      repeat (3) begin @(negedge clk); lat++; end
      bus.start = 1'b1; bus.flp_a = 16'h3C00; bus.flp_b = 16'h4200;
      @(negedge clk); lat++;
      bus.start = 1'b0;
      got = 1'b0;
      while (lat <= 40) begin
         if (bus.done) begin got = 1'b1; break; end
         @(negedge clk); lat++;
      end
      total++;
      if (!got || bus.quot !== 16'h4200 || lat !== 14) begin
         bad++; $display("FAIL ignored_start got=%h/%0d exp=4200/14", bus.quot, lat);
      end
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignored_start_idle got=%b exp=0", bus.busy); end
   endtask

   task automatic test_back_to_back;
      int lat; bit got;
      @(negedge clk);
      bus.start = 1'b1; bus.flp_a = 16'h4600; bus.flp_b = 16'h4000;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1; got = 1'b0;
      while (lat <= 40) begin
         if (bus.done) begin got = 1'b1; break; end
         @(negedge clk); lat++;
      end
      total++;
      if (!got || bus.quot !== 16'h4200) begin
         bad++; $display("FAIL b2b_first got=%h exp=4200", bus.quot);
      end
      bus.start = 1'b1; bus.flp_a = 16'hC800; bus.flp_b = 16'h3800;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1; got = 1'b0;
      while (lat <= 40) begin
         if (bus.done) begin got = 1'b1; break; end
         @(negedge clk); lat++;
      end
      total++;
      if (!got || bus.quot !== 16'hCC00 || lat !== 14) begin
         bad++; $display("FAIL b2b_second got=%h/%0d exp=cc00/14", bus.quot, lat);
      end
   endtask

   task automatic test_reset_abort;
      logic [15:0] q; logic [3:0] f; int lat, bc; bit got; int seen;
      @(negedge clk);
      bus.start = 1'b1; bus.flp_a = 16'h4600; bus.flp_b = 16'h4000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.quot !== 16'h0000 || bus.done !== 1'b0) begin
         bad++; $display("FAIL abort_state got=%b/%h/%b exp=0/0000/0", bus.busy, bus.quot, bus.done);
      end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
      run_div(16'h4600, 16'h4000, q, f, lat, bc, got);
      total++;
      if (!got || q !== 16'h4200 || f !== 4'b0000 || lat !== 14) begin
         bad++; $display("FAIL abort_recover got=%h/%b/%0d exp=4200/0000/14", q, f, lat);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.flp_a = '0;
      bus.flp_b = '0;
      test_reset;
      test_basic;
      test_normalise;
      test_special;
      test_range;
      test_ignored_start;
      test_back_to_back;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
